// File: rtl/seg7_mux_hex_driver.sv
// Time-multiplexed hex driver for an N-digit common-anode 7-segment display.
// New values wait in a shadow register and are committed only at frame boundaries.
module seg7_mux_hex_driver #(
    parameter int NUM_DIGITS    = 8,
    parameter int REFRESH_DIV   = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                    CLK100MHZ,
    input  logic                    CPU_RESETN,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    CA,
    output logic                    CB,
    output logic                    CC,
    output logic                    CD,
    output logic                    CE,
    output logic                    CF,
    output logic                    CG,
    output logic                    DP,
    output logic                    frame_tick
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int DW = 4 * NUM_DIGITS;

    logic [CW-1:0]         slot_cnt;
    logic [IW-1:0]         idx;
    logic [DW-1:0]         disp_val, shad_val;
    logic [NUM_DIGITS-1:0] disp_dp, shad_dp;
    logic                  pending;
    logic                  slot_end, boundary;
    logic [NUM_DIGITS-1:0] zero_above;
    logic [3:0]            nib;
    logic                  lit;
    logic [6:0]            seg_n;
    logic [NUM_DIGITS-1:0] an_q;
    logic [6:0]            seg_q;
    logic                  dp_q;
    logic                  tick_pre, tick_q;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 7'b0000001;
            4'h1: hex_to_seg = 7'b1001111;
            4'h2: hex_to_seg = 7'b0010010;
            4'h3: hex_to_seg = 7'b0000110;
            4'h4: hex_to_seg = 7'b1001100;
            4'h5: hex_to_seg = 7'b0100100;
            4'h6: hex_to_seg = 7'b0100000;
            4'h7: hex_to_seg = 7'b0001111;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0000100;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b1100000;
            4'hC: hex_to_seg = 7'b0110001;
            4'hD: hex_to_seg = 7'b1000010;
            4'hE: hex_to_seg = 7'b0110000;
            default: hex_to_seg = 7'b0111000;
        endcase
    endfunction

    assign slot_end = (slot_cnt == CW'(REFRESH_DIV - 1));
    assign boundary = slot_end && (idx == IW'(NUM_DIGITS - 1));

    // zero_above[k]: every nibble from k upward is zero, i.e. digit k is a leading zero
    always_comb begin
        zero_above = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            zero_above[k] = ((disp_val >> (4 * k)) == '0);
        end
    end

    always_comb begin
        nib   = 4'(disp_val >> {idx, 2'b00});
        seg_n = hex_to_seg(nib);
        lit   = digit_en[idx] && !(BLANK_LEADING && (idx != '0) && zero_above[idx]);
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            slot_cnt <= '0;
            idx      <= '0;
            disp_val <= '0;
            disp_dp  <= '0;
            shad_val <= '0;
            shad_dp  <= '0;
            pending  <= 1'b0;
            an_q     <= '1;
            seg_q    <= '1;
            dp_q     <= 1'b1;
            tick_pre <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
            if (slot_end) begin
                idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end

            if (boundary) begin
                pending <= 1'b0;
                if (load) begin
                    disp_val <= value;
                    disp_dp  <= dp_in;
                end else if (pending) begin
                    disp_val <= shad_val;
                    disp_dp  <= shad_dp;
                end
            end else if (load) begin
                shad_val <= value;
                shad_dp  <= dp_in;
                pending  <= 1'b1;
            end

            an_q  <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
            seg_q <= lit ? seg_n : '1;
            dp_q  <= lit ? ~disp_dp[idx] : 1'b1;

            // Two stages so the pulse lines up with digit 0 reaching the outputs
            tick_pre <= boundary;
            tick_q   <= tick_pre;
        end
    end

    assign AN                         = an_q;
    assign {CA, CB, CC, CD, CE, CF, CG} = seg_q;
    assign DP                         = dp_q;
    assign frame_tick                 = tick_q;

endmodule

// File: tb/tb_seg7_mux_hex_driver.sv
// Bench for seg7_mux_hex_driver: two instances (blanking off/on) checked every cycle
// against a time-based reference model driven by directed and random stimulus.
module tb_seg7_mux_hex_driver;

    localparam int N  = 4;
    localparam int RD = 4;
    localparam int F  = N * RD;

    logic         clk;
    logic         rstn;
    logic [15:0]  value;
    logic         load;
    logic [3:0]   dp_in;
    logic [3:0]   digit_en;

    logic [3:0]   an0, an1;
    logic [6:0]   seg0, seg1;
    logic         dp0, dp1, tick0, tick1;

    int tests  = 0;
    int errors = 0;

    // reference model state
    int          t;
    logic [15:0] m_disp, m_shad;
    logic [3:0]  m_dp, m_shdp;
    bit          m_pend;
    logic [3:0]  e_an  [2];
    logic [6:0]  e_seg [2];
    logic        e_dp  [2];
    logic        e_tick;
    logic [6:0]  seg_tab [16];

    seg7_mux_hex_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_LEADING(1'b0)) u_dut0 (
        .CLK100MHZ(clk), .CPU_RESETN(rstn), .value(value), .load(load),
        .dp_in(dp_in), .digit_en(digit_en), .AN(an0),
        .CA(seg0[6]), .CB(seg0[5]), .CC(seg0[4]), .CD(seg0[3]),
        .CE(seg0[2]), .CF(seg0[1]), .CG(seg0[0]),
        .DP(dp0), .frame_tick(tick0)
    );

    seg7_mux_hex_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_LEADING(1'b1)) u_dut1 (
        .CLK100MHZ(clk), .CPU_RESETN(rstn), .value(value), .load(load),
        .dp_in(dp_in), .digit_en(digit_en), .AN(an1),
        .CA(seg1[6]), .CB(seg1[5]), .CC(seg1[4]), .CD(seg1[3]),
        .CE(seg1[2]), .CF(seg1[1]), .CG(seg1[0]),
        .DP(dp1), .frame_tick(tick1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @t=%0d: got %h expected %h", tag, t, obs, exp);
        end
    endtask

    // One clock edge of the reference: outputs from the digit selected by elapsed time.
    task automatic model_edge();
        int          di;
        logic [15:0] upper;
        logic [3:0]  nib;
        bit          blanked, lit, bnd;
        if (!rstn) begin
            t = 0; m_disp = '0; m_shad = '0; m_dp = '0; m_shdp = '0; m_pend = 0;
            for (int c = 0; c < 2; c++) begin
                e_an[c] = 4'hF; e_seg[c] = 7'h7F; e_dp[c] = 1'b1;
            end
            e_tick = 1'b0;
        end else begin
            di    = (t / RD) % N;
            bnd   = ((t % F) == F - 1);
            upper = m_disp >> (4 * di);
            nib   = upper[3:0];
            for (int c = 0; c < 2; c++) begin
                blanked  = (c == 1) && (di > 0) && (upper == 16'h0);
                lit      = digit_en[di] && !blanked;
                e_an[c]  = lit ? 4'(~(4'b0001 << di)) : 4'hF;
                e_seg[c] = lit ? seg_tab[nib] : 7'h7F;
                e_dp[c]  = lit ? ~m_dp[di] : 1'b1;
            end
            e_tick = (t > 0) && ((t % F) == 0);
            if (bnd) begin
                if (load) begin
                    m_disp = value; m_dp = dp_in;
                end else if (m_pend) begin
                    m_disp = m_shad; m_dp = m_shdp;
                end
                m_pend = 0;
            end else if (load) begin
                m_shad = value; m_shdp = dp_in; m_pend = 1;
            end
            t++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("an_noblank",   32'(an0),   32'(e_an[0]));
        chk("seg_noblank",  32'(seg0),  32'(e_seg[0]));
        chk("dp_noblank",   32'(dp0),   32'(e_dp[0]));
        chk("tick_noblank", 32'(tick0), 32'(e_tick));
        chk("an_blank",     32'(an1),   32'(e_an[1]));
        chk("seg_blank",    32'(seg1),  32'(e_seg[1]));
        chk("dp_blank",     32'(dp1),   32'(e_dp[1]));
        chk("tick_blank",   32'(tick1), 32'(e_tick));
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < F && (t % F) != ph; i++) cycle();
    endtask

    initial begin
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        t = 0;
        rstn = 1'b0; value = 16'h12A4; load = 1'b0; dp_in = 4'h0; digit_en = 4'hF;

        // reset held 3 cycles, with a load strobe that reset must override
        load = 1'b1;
        run(3);
        rstn = 1'b1;
        value = 16'h12A4; load = 1'b1;
        run(2 * F + 2);

        // leading-zero blanking
        value = 16'h0005; load = 1'b1;
        run(2 * F);
        value = 16'h0000; load = 1'b1;
        run(2 * F);

        // mid-frame load while digit 1 is active
        wait_phase(RD + 1);
        value = 16'h1111; load = 1'b1;
        run(2 * F);

        // boundary collision: pending 0x1111 superseded by a load in the boundary cycle
        wait_phase(2);
        value = 16'h1111; load = 1'b1;
        cycle();
        wait_phase(F - 1);
        value = 16'h00F0; load = 1'b1;
        run(2 * F);

        // digit enable mask and decimal points
        digit_en = 4'b1011; dp_in = 4'b0001; value = 16'h8C3E; load = 1'b1;
        run(2 * F + 1);
        dp_in = 4'h0;

        // reset during digit 2 with a pending load
        wait_phase(2 * RD + 1);
        value = 16'h7777; load = 1'b1;
        cycle();
        rstn = 1'b0;
        cycle();
        rstn = 1'b1; digit_en = 4'hF;
        run(2 * F);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                value = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
                dp_in = 4'($urandom);
                load  = 1'b1;
            end
            if ($urandom_range(0, 63) == 0) digit_en = 4'($urandom);
            rstn = ($urandom_range(0, 399) != 0);
            cycle();
        end
        rstn = 1'b1;
        run(F);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/seg7_mux_hex_driver.md
Name: seg7_mux_hex_driver

Overview:
- Time-multiplexed hex driver for an N-digit common-anode 7-segment display; successor to the single-digit combinational digit driver.
- Captures an N-nibble value with a load strobe and scans one digit per refresh slot.
- Supports per-digit decimal points, a digit enable mask and optional leading-zero blanking.
- Holds new values in a shadow register and commits them only at frame boundaries, so a partial update never appears on the display.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (1..8); AN width.
- REFRESH_DIV, 100000, clock cycles per digit slot (>=2); default gives 1 ms per digit at 100 MHz.
- BLANK_LEADING, 1, 1 = blank leading zero digits above digit 0; 0 = always show all digits.

Ports:
- CLK100MHZ  input  1  system clock; all logic on its rising edge.
- CPU_RESETN  input  1  synchronous active-low reset.
- value  input  4*NUM_DIGITS  hex nibbles; nibble k (bits 4k+3:4k) is shown on digit k.
- load  input  1  single-cycle strobe; captures value and dp_in.
- dp_in  input  NUM_DIGITS  decimal-point request per digit, active-high.
- digit_en  input  NUM_DIGITS  live (not captured) per-digit enable, active-high.
- AN  output  NUM_DIGITS  digit anodes, active-low, at most one low.
- CA, CB, CC, CD, CE, CF, CG  output  1 each  segments, active-low.
- DP  output  1  decimal point, active-low.
- frame_tick  output  1  one-cycle pulse when the scan wraps back to digit 0.

Behaviour:
- Reset (CPU_RESETN=0 at a clock edge):
  - slot counter = 0, digit index = 0.
  - display register and shadow register = 0; pending flag cleared.
  - AN = all 1; CA..CG = 1; DP = 1; frame_tick = 0.
  - Reset takes priority over load.
- Reset mid-scan aborts the scan and discards any pending value.
- Slot counter:
  - Counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it returns to 0 and the digit index advances.
  - Digit index wraps from NUM_DIGITS-1 to 0.
  - The cycle where the index wraps is the frame boundary.
- Index width is max(1, clog2(NUM_DIGITS)).
- Shadow register and pending flag:
  - load=1 outside a frame boundary: shadow takes {value, dp_in} and the pending flag is set.
  - Repeated loads overwrite the shadow; the last load before the boundary wins.
- At a frame boundary:
  - If pending, the display register takes the shadow contents and the pending flag clears.
  - If load=1 in the boundary cycle itself, the display register takes {value, dp_in} directly, bypassing the shadow, and the pending flag clears.
- Output registers are updated every cycle from the current index and display register, giving one cycle of latency from an index change to AN/segments.
- AN: bit[index] = 0 and all other bits = 1, unless the digit is disabled or blanked, in which case AN is all 1 for that slot. A disabled or blanked digit still consumes its slot.
- Blanking, when BLANK_LEADING=1:
  - Digit k (k>=1) is blanked if nibbles k..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - A blanked digit also forces DP=1.
- DP = ~dp_reg[index] when the digit is lit.
- Segment decode, written as {CA..CG} active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- frame_tick is registered: it is high for exactly the one cycle after the frame-boundary edge, aligned with the first output cycle of digit 0.
- Outputs are glitch-free: all of AN, CA..CG and DP come from flops.

Test Plan:
- Reset and load: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_LEADING=0. Hold reset 3 cycles, load 0x12A4 then wait one frame. Required: AN=1111 and segs all 1 during reset. After the commit, the scan shows AN=1110 with 1001100 (4), then 1101 with 0001000 (A), then 1011 with 0010010 (2), then 0111 with 1001111 (1). Each slot lasts 4 cycles and frame_tick pulses every 16 cycles.
- Leading-zero blanking: BLANK_LEADING=1, value=0x0005. Required: digits 3..1 show AN=1111 for their slots; digit 0 shows 0100100. value=0x0000 shows only digit 0 as 0000001.
- Mid-frame load: load 0x1111 while digit 1 is active. Required: the remaining slots of the current frame still show the old value; 1001111 on all digits starts with the next frame.
- Boundary collision: load 0x00F0 (previous pending 0x1111) in the exact frame-boundary cycle. Required: the next frame shows 0x00F0, with no frame of 0x1111.
- digit_en and DP: digit_en=1011, dp_in=0001. Required: digit 2 slot has AN=1111; digit 0 has DP=0; all other digits have DP=1.
- Reset mid-scan: assert CPU_RESETN=0 during digit 2 with a load pending. Required: the next edge gives AN=1111; after release the scan restarts at digit 0 showing 0 with no pending commit.
